// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO.
//   fifo_cw()    : width of a fill-level counter able to hold 0..depth
//   fifo_err_t   : sticky {overflow, underflow} status pair
//   DEF_*        : default geometry used by the top level
package syn_fifo_pkg;

    // A level counter must represent DEPTH itself, so it needs one more code
    // than the pointer range.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_CW         = fifo_cw(DEF_DEPTH);

endpackage

// File: rtl/syn_fifo_ram.sv
// Storage array for syn_fifo_prog.
// One synchronous write port, one asynchronous read port, no reset.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
module syn_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write contents during a same-address write, which is
    // what gives "old word" semantics on a full-FIFO read+write.
    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/syn_fifo_prog.sv
// Programmable single-clock FIFO with exact full/empty at any depth,
// almost-full/almost-empty thresholds, fill level, sticky error flags,
// synchronous flush and optional first-word-fall-through output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous empty (ignores w_en/r_en that cycle)
//   clr_err             : clears sticky overflow/underflow
//   w_en, data_in       : write request and data
//   r_en                : read/pop request
//   data_out            : read data (registered, or head word when FWFT=1)
//   full, empty         : level==DEPTH / level==0
//   almost_full/_empty  : level >= AF_THRESH / level <= AE_THRESH
//   level               : number of words held
//   overflow, underflow : sticky rejected-write / rejected-read flags
module syn_fifo_prog
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         clr_err,
    input  logic                         w_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         r_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [fifo_cw(DEPTH)-1:0]    level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = fifo_cw(DEPTH);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE_CW  = CW'(1);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_AW  = AW'(1);

    // Elaboration-time parameter sanity
    if (DEPTH < 2) begin : g_chk_depth
        $error("syn_fifo_prog: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("syn_fifo_prog: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_chk_ae
        $error("syn_fifo_prog: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [AW-1:0]         w_ptr_q, w_ptr_d;
    logic [AW-1:0]         r_ptr_q, r_ptr_d;
    logic [CW-1:0]         level_q, level_d;
    fifo_err_t             err_q, err_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rd_ok;
    logic                  wr_ok;

    // Flags straight from the registered level
    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_C);
    assign almost_full  = (level_q >= AF_C);
    assign almost_empty = (level_q <= AE_C);
    assign level        = level_q;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

    // A full FIFO still accepts a write when a read frees a slot this cycle.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        level_d = level_q;
        err_d   = err_q;
        if (flush) begin
            // Requests are dropped silently; sticky flags keep their value.
            w_ptr_d = '0;
            r_ptr_d = '0;
            level_d = '0;
        end else begin
            // Explicit wrap keeps non-power-of-2 depths correct.
            if (wr_ok) begin
                w_ptr_d = (w_ptr_q == LAST_C) ? '0 : w_ptr_q + ONE_AW;
            end
            if (rd_ok) begin
                r_ptr_d = (r_ptr_q == LAST_C) ? '0 : r_ptr_q + ONE_AW;
            end
            if (wr_ok && !rd_ok) begin
                level_d = level_q + ONE_CW;
            end else if (rd_ok && !wr_ok) begin
                level_d = level_q - ONE_CW;
            end
            // Setting wins over clearing in the same cycle.
            err_d.overflow  = (w_en & ~wr_ok) | (err_q.overflow  & ~clr_err);
            err_d.underflow = (r_en & ~rd_ok) | (err_q.underflow & ~clr_err);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
            err_q   <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    syn_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_ok & ~flush),
        .waddr_i (w_ptr_q),
        .wdata_i (data_in),
        .raddr_i (r_ptr_q),
        .rdata_o (ram_rdata)
    );

    if (FWFT == 0) begin : g_reg_out
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_ok && !flush) begin
                dout_d = ram_rdata;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end else begin : g_fwft_out
        // Head word is presented directly; zero when nothing is held.
        assign data_out = empty ? '0 : ram_rdata;
    end

endmodule

// File: tb/tb_syn_fifo_prog.sv
module tb_syn_fifo_prog;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A: DEPTH 8, AF 6, AE 1, registered output
    logic       a_flush = 0, a_clr = 0, a_w_en = 0, a_r_en = 0;
    logic [7:0] a_data_in = 0, a_data_out;
    logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic [3:0] a_level;

    syn_fifo_prog #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .clr_err(a_clr), .w_en(a_w_en),
        .data_in(a_data_in), .r_en(a_r_en), .data_out(a_data_out), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .level(a_level),
        .overflow(a_ov), .underflow(a_un));

    // ---------------- instance B: DEPTH 5 (wrap), registered output
    logic       b_flush = 0, b_clr = 0, b_w_en = 0, b_r_en = 0;
    logic [7:0] b_data_in = 0, b_data_out;
    logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [2:0] b_level;

    syn_fifo_prog #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .clr_err(b_clr), .w_en(b_w_en),
        .data_in(b_data_in), .r_en(b_r_en), .data_out(b_data_out), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .level(b_level),
        .overflow(b_ov), .underflow(b_un));

    // ---------------- instance C: DEPTH 4, first-word-fall-through
    logic       c_flush = 0, c_clr = 0, c_w_en = 0, c_r_en = 0;
    logic [7:0] c_data_in = 0, c_data_out;
    logic       c_full, c_empty, c_af, c_ae, c_ov, c_un;
    logic [2:0] c_level;

    syn_fifo_prog #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .clr_err(c_clr), .w_en(c_w_en),
        .data_in(c_data_in), .r_en(c_r_en), .data_out(c_data_out), .full(c_full),
        .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae), .level(c_level),
        .overflow(c_ov), .underflow(c_un));

    // ---------------- scoreboard: contents queue and expected-read queue
    logic [7:0] mq_a[$], exp_a[$], mq_b[$], exp_b[$];
    bit a_rd, a_wr, b_rd, b_wr;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq_a.delete(); exp_a.delete();
        end else if (a_flush) begin
            mq_a.delete();
        end else begin
            a_rd = a_r_en && (mq_a.size() != 0);
            a_wr = a_w_en && ((mq_a.size() < 8) || a_rd);
            if (a_rd) exp_a.push_back(mq_a.pop_front());
            if (a_wr) mq_a.push_back(a_data_in);
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            mq_b.delete(); exp_b.delete();
        end else if (b_flush) begin
            mq_b.delete();
        end else begin
            b_rd = b_r_en && (mq_b.size() != 0);
            b_wr = b_w_en && ((mq_b.size() < 5) || b_rd);
            if (b_rd) exp_b.push_back(mq_b.pop_front());
            if (b_wr) mq_b.push_back(b_data_in);
        end
    end

    // Reset may be pulsed between clock edges; stored words are lost.
    always @(negedge rst_n) begin
        mq_a.delete(); exp_a.delete();
        mq_b.delete(); exp_b.delete();
    end

    // Monitor: each accepted read presents its word one cycle later.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_a.size() != 0) chk("A rdata", 32'(a_data_out), 32'(exp_a.pop_front()));
            if (exp_b.size() != 0) chk("B rdata", 32'(b_data_out), 32'(exp_b.pop_front()));
            chk("A level", 32'(a_level), 32'(mq_a.size()));
            chk("B level", 32'(b_level), 32'(mq_b.size()));
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        // reset state
        chk("A rst empty", 32'(a_empty), 1);
        chk("A rst full", 32'(a_full), 0);
        chk("A rst ae", 32'(a_ae), 1);
        chk("A rst af", 32'(a_af), 0);
        chk("A rst level", 32'(a_level), 0);
        chk("A rst dout", 32'(a_data_out), 0);
        chk("A rst ov", 32'(a_ov), 0);
        chk("A rst un", 32'(a_un), 0);
        chk("C rst dout", 32'(c_data_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- fill / drain DEPTH 8 with threshold checks
        for (int i = 1; i <= 8; i++) begin
            a_w_en = 1; a_data_in = 8'(i);
            @(negedge clk);
            if (i == 1) chk("A ae@1", 32'(a_ae), 1);
            if (i == 2) chk("A ae@2", 32'(a_ae), 0);
            if (i == 5) chk("A af@5", 32'(a_af), 0);
            if (i == 6) chk("A af@6", 32'(a_af), 1);
            if (i == 7) chk("A full@7", 32'(a_full), 0);
        end
        a_w_en = 0;
        chk("A full@8", 32'(a_full), 1);
        chk("A level@8", 32'(a_level), 8);
        for (int j = 1; j <= 8; j++) begin
            a_r_en = 1;
            @(negedge clk);
            if (j == 2) chk("A af@6dn", 32'(a_af), 1);
            if (j == 3) chk("A af@5dn", 32'(a_af), 0);
            if (j == 7) chk("A ae@1dn", 32'(a_ae), 1);
        end
        a_r_en = 0;
        chk("A empty end", 32'(a_empty), 1);
        chk("A dout hold", 32'(a_data_out), 8'h08);

        // ---- DEPTH 5 wrap, 3 rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                b_w_en = 1; b_data_in = 8'(16 * (r + 1) + k);
                @(negedge clk);
                if (k == 3) chk("B full@4", 32'(b_full), 0);
            end
            b_w_en = 0;
            chk("B full@5", 32'(b_full), 1);
            chk("B level@5", 32'(b_level), 5);
            for (int k = 0; k < 5; k++) begin
                b_r_en = 1;
                @(negedge clk);
                if (k == 3) chk("B empty@1", 32'(b_empty), 0);
            end
            b_r_en = 0;
            chk("B empty@0", 32'(b_empty), 1);
            chk("B level@0", 32'(b_level), 0);
        end

        // ---- full with read+write, overflow, underflow
        for (int k = 0; k < 5; k++) begin
            b_w_en = 1; b_data_in = 8'h51 + 8'(k);
            @(negedge clk);
        end
        b_r_en = 1; b_data_in = 8'h56;
        @(negedge clk);
        b_r_en = 0;
        chk("B rw level", 32'(b_level), 5);
        chk("B rw full", 32'(b_full), 1);
        chk("B rw ov", 32'(b_ov), 0);
        chk("B rw dout", 32'(b_data_out), 8'h51);
        b_data_in = 8'h57;
        @(negedge clk);
        b_w_en = 0;
        chk("B ov set", 32'(b_ov), 1);
        chk("B ov level", 32'(b_level), 5);
        @(negedge clk);
        chk("B ov sticky", 32'(b_ov), 1);
        b_clr = 1;
        @(negedge clk);
        b_clr = 0;
        chk("B ov clr", 32'(b_ov), 0);
        for (int k = 0; k < 5; k++) begin
            b_r_en = 1;
            @(negedge clk);
        end
        chk("B last dout", 32'(b_data_out), 8'h56);
        @(negedge clk);
        b_r_en = 0;
        chk("B un set", 32'(b_un), 1);
        chk("B un level", 32'(b_level), 0);
        b_r_en = 1; b_clr = 1;
        @(negedge clk);
        b_r_en = 0;
        chk("B un set>clr", 32'(b_un), 1);
        @(negedge clk);
        b_clr = 0;
        chk("B un clr", 32'(b_un), 0);

        // ---- FWFT
        c_w_en = 1; c_data_in = 8'hA5;
        @(negedge clk);
        c_w_en = 0;
        chk("C fwft show", 32'(c_data_out), 8'hA5);
        chk("C fwft !empty", 32'(c_empty), 0);
        @(negedge clk);
        chk("C fwft hold", 32'(c_data_out), 8'hA5);
        c_r_en = 1;
        @(negedge clk);
        c_r_en = 0;
        chk("C pop empty", 32'(c_empty), 1);
        chk("C pop dout0", 32'(c_data_out), 0);
        c_w_en = 1; c_data_in = 8'hB1;
        @(negedge clk);
        c_data_in = 8'hB2;
        @(negedge clk);
        c_w_en = 0;
        chk("C head B1", 32'(c_data_out), 8'hB1);
        c_r_en = 1;
        @(negedge clk);
        chk("C head B2", 32'(c_data_out), 8'hB2);
        @(negedge clk);
        c_r_en = 0;
        chk("C drained", 32'(c_data_out), 0);

        // ---- flush with pending write
        for (int k = 0; k < 4; k++) begin
            a_w_en = 1; a_data_in = 8'h11 + 8'(k);
            @(negedge clk);
        end
        a_flush = 1; a_data_in = 8'h99;
        @(negedge clk);
        a_flush = 0; a_w_en = 0;
        chk("A flush level", 32'(a_level), 0);
        chk("A flush empty", 32'(a_empty), 1);
        chk("A flush ov", 32'(a_ov), 0);
        chk("A flush dout", 32'(a_data_out), 8'h08);

        // ---- reset pulse between edges, mid-stream
        a_w_en = 1; a_data_in = 8'h21;
        @(negedge clk);
        a_data_in = 8'h22;
        @(negedge clk);
        a_r_en = 1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("A rstmid level", 32'(a_level), 0);
        chk("A rstmid empty", 32'(a_empty), 1);
        chk("A rstmid dout", 32'(a_data_out), 0);
        chk("A rstmid full", 32'(a_full), 0);
        rst_n = 1'b1;
        a_w_en = 0; a_r_en = 0;
        @(negedge clk);
        a_w_en = 1; a_data_in = 8'h31;
        @(negedge clk);
        a_w_en = 0; a_r_en = 1;
        @(negedge clk);
        a_r_en = 0;
        chk("A post-rst dout", 32'(a_data_out), 8'h31);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
